// File: rtl/riscv_hazard_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : riscv_hazard_scheduler
// Purpose  : In-order RISC-V decode issue control. Tracks the EX/MEM/WB
//            destination registers, stalls decode on RAW hazards, inserts
//            bubbles, flushes on taken branches and counts stall cycles.
//            Build option RISCV_HAZARD_FORWARDING_EN enables operand
//            forwarding, which reduces stalls to the load-use case only.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_hazard_scheduler #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [31:0]            id_instr,
  input  logic                   br_taken,
  output logic                   id_ready,
  output logic                   flush_if_id,
  output logic                   bubble,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_U    = 7'b0110111;
  localparam logic [6:0] OP_J    = 7'b1101111;

  typedef struct packed {
    logic       valid;
    logic       writes;
    logic [4:0] rd;
    logic       is_load;
  } slot_t;

  logic [4:0] rs1, rs2, rd;
  logic [6:0] opcode;
  logic       reads_rs1, reads_rs2, writes_rd, is_load;
  slot_t      ex_slot, mem_slot, wb_slot, ex_next;
  logic       ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
  logic       hazard_raw, hazard, issue, stall_evt;
  logic [1:0] fwd_a_next, fwd_b_next;
  logic       unused_bits;

  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];
  assign rd     = id_instr[11:7];
  assign opcode = id_instr[6:0];

  // A source only matters when it is actually read and is not x0.
  function automatic logic slot_hit(input slot_t s, input logic [4:0] src, input logic used);
    return used && (src != 5'd0) && s.valid && s.writes && (s.rd == src);
  endfunction

  // Classify which register fields the decode instruction reads and writes.
  always_comb begin
    reads_rs1 = 1'b0;
    reads_rs2 = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    case (opcode)
      OP_R:    begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; writes_rd = 1'b1; end
      OP_I:    begin reads_rs1 = 1'b1; writes_rd = 1'b1; end
      OP_S:    begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; end
      OP_B:    begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; end
      OP_LOAD: begin reads_rs1 = 1'b1; writes_rd = 1'b1; is_load = 1'b1; end
      OP_U:    writes_rd = 1'b1;
      OP_J:    writes_rd = 1'b1;
      default: ;
    endcase
    if (rd == 5'd0) writes_rd = 1'b0;
  end

  assign ex_hit_a  = slot_hit(ex_slot,  rs1, reads_rs1);
  assign ex_hit_b  = slot_hit(ex_slot,  rs2, reads_rs2);
  assign mem_hit_a = slot_hit(mem_slot, rs1, reads_rs1);
  assign mem_hit_b = slot_hit(mem_slot, rs2, reads_rs2);
  assign wb_hit_a  = slot_hit(wb_slot,  rs1, reads_rs1);
  assign wb_hit_b  = slot_hit(wb_slot,  rs2, reads_rs2);

`ifdef RISCV_HAZARD_FORWARDING_EN
  // Only a load still in EX cannot be forwarded; the youngest producer wins.
  always_comb begin
    hazard_raw  = ex_slot.is_load & (ex_hit_a | ex_hit_b);
    fwd_a_next  = ex_hit_a ? 2'b01 : (mem_hit_a ? 2'b10 : 2'b00);
    fwd_b_next  = ex_hit_b ? 2'b01 : (mem_hit_b ? 2'b10 : 2'b00);
    unused_bits = &{mem_slot.is_load, wb_slot.is_load, wb_hit_a, wb_hit_b,
                    id_instr[31:25], id_instr[14:12]};
  end
`else
  // Without forwarding any in-flight producer blocks issue until it retires.
  always_comb begin
    hazard_raw  = ex_hit_a | ex_hit_b | mem_hit_a | mem_hit_b | wb_hit_a | wb_hit_b;
    fwd_a_next  = 2'b00;
    fwd_b_next  = 2'b00;
    unused_bits = &{ex_slot.is_load, mem_slot.is_load, wb_slot.is_load,
                    id_instr[31:25], id_instr[14:12]};
  end
`endif

  assign hazard      = id_valid & hazard_raw;
  assign id_ready    = rst & ~hazard & ~br_taken;
  assign flush_if_id = br_taken;
  assign issue       = id_valid & id_ready;
  assign stall_evt   = hazard & ~br_taken;

  // The issued instruction enters EX; anything else becomes an empty slot.
  always_comb begin
    ex_next = '0;
    if (issue) begin
      ex_next.valid   = 1'b1;
      ex_next.writes  = writes_rd;
      ex_next.rd      = rd;
      ex_next.is_load = is_load;
    end
  end

  // Advance the in-flight slots and register the per-issue outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_slot   <= '0;
      mem_slot  <= '0;
      wb_slot   <= '0;
      bubble    <= 1'b0;
      fwd_a_sel <= 2'b00;
      fwd_b_sel <= 2'b00;
      stall_cnt <= '0;
    end else begin
      ex_slot   <= ex_next;
      mem_slot  <= ex_slot;
      wb_slot   <= mem_slot;
      bubble    <= stall_evt;
      fwd_a_sel <= issue ? fwd_a_next : 2'b00;
      fwd_b_sel <= issue ? fwd_b_next : 2'b00;
      if (stall_evt && (stall_cnt != {STALL_CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_hazard_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_hazard_scheduler
// Purpose  : Directed self-checking bench for riscv_hazard_scheduler. Adapts
//            its expectations to RISCV_HAZARD_FORWARDING_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_hazard_scheduler;

`ifdef RISCV_HAZARD_FORWARDING_EN
  localparam int         ALU_STALLS = 0;
  localparam int         LD_STALLS  = 1;
  localparam logic [1:0] ALU_FWD_A  = 2'b01;
  localparam logic [1:0] LD_FWD     = 2'b10;
  localparam int         SAT_PAIRS  = 5;
`else
  localparam int         ALU_STALLS = 3;
  localparam int         LD_STALLS  = 3;
  localparam logic [1:0] ALU_FWD_A  = 2'b00;
  localparam logic [1:0] LD_FWD     = 2'b00;
  localparam int         SAT_PAIRS  = 2;
`endif

  logic        clk = 1'b0;
  logic        rst, id_valid, br_taken;
  logic [31:0] id_instr;
  logic        id_ready, flush_if_id, bubble;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt;
  logic        id_ready2, flush_if_id2, bubble2;
  logic [1:0]  fwd_a_sel2, fwd_b_sel2;
  logic [1:0]  stall_cnt2;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  riscv_hazard_scheduler dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .br_taken(br_taken), .id_ready(id_ready), .flush_if_id(flush_if_id),
    .bubble(bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt)
  );

  riscv_hazard_scheduler #(.STALL_CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .br_taken(br_taken), .id_ready(id_ready2), .flush_if_id(flush_if_id2),
    .bubble(bubble2), .fwd_a_sel(fwd_a_sel2), .fwd_b_sel(fwd_b_sel2),
    .stall_cnt(stall_cnt2)
  );

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] d,
                                        input logic [4:0] s1, input logic [4:0] s2);
    return {f7, s2, s1, 3'b000, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [4:0] d, input logic [4:0] s1,
                                           input logic [11:0] imm);
    return {imm, s1, 3'b000, d, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_lw(input logic [4:0] d, input logic [4:0] s1);
    return {12'd0, s1, 3'b010, d, 7'b0000011};
  endfunction

  // Single comparison point for every check in the bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Empty the pipeline by presenting no instruction for three cycles.
  task automatic drain();
    id_valid = 1'b0;
    br_taken = 1'b0;
    repeat (3) tick();
  endtask

  // Issue a producer, then a dependent consumer; expect nst stall cycles and
  // the given forwarding selects once the consumer reaches EX.
  task automatic run_dep(input string tag, input logic [31:0] prod, input logic [31:0] cons,
                         input int nst, input logic [1:0] fa, input logic [1:0] fb);
    id_valid = 1'b1;
    br_taken = 1'b0;
    id_instr = prod;
    #1 check({tag, ":prod_rdy"}, 32'(id_ready), 32'd1);
    tick();
    id_instr = cons;
    for (int i = 0; i < nst; i++) begin
      #1 check({tag, ":stall_rdy"}, 32'(id_ready), 32'd0);
      tick();
      exp_cnt++;
      check({tag, ":bubble"}, 32'(bubble), 32'd1);
    end
    #1 check({tag, ":cons_rdy"}, 32'(id_ready), 32'd1);
    tick();
    check({tag, ":no_bubble"}, 32'(bubble), 32'd0);
    check({tag, ":fwd_a"}, 32'(fwd_a_sel), 32'(fa));
    check({tag, ":fwd_b"}, 32'(fwd_b_sel), 32'(fb));
    check({tag, ":cnt"}, 32'(stall_cnt), 32'(exp_cnt));
  endtask

  initial begin
    rst      = 1'b0;
    id_valid = 1'b1;
    br_taken = 1'b0;
    id_instr = enc_addi(5'd0, 5'd0, 12'd0);
    tick();
    tick();
    check("rst_rdy",    32'(id_ready),  32'd0);
    check("rst_bubble", 32'(bubble),    32'd0);
    check("rst_fwd_a",  32'(fwd_a_sel), 32'd0);
    check("rst_fwd_b",  32'(fwd_b_sel), 32'd0);
    check("rst_cnt",    32'(stall_cnt), 32'd0);
    rst = 1'b1;
    drain();

    // add x1,x2,x3 ; sub x4,x1,x5
    run_dep("alu", enc_r(7'b0000000, 5'd1, 5'd2, 5'd3),
            enc_r(7'b0100000, 5'd4, 5'd1, 5'd5), ALU_STALLS, ALU_FWD_A, 2'b00);
    drain();

    // lw x6,0(x2) ; add x7,x6,x6
    run_dep("ld", enc_lw(5'd6, 5'd2), enc_r(7'b0, 5'd7, 5'd6, 5'd6),
            LD_STALLS, LD_FWD, LD_FWD);
    drain();
    check("idle_bubble", 32'(bubble), 32'd0);

    // addi x0,x0,5 ; add x2,x0,x0 -- x0 never creates a dependency
    run_dep("x0", enc_addi(5'd0, 5'd0, 12'd5), enc_r(7'b0, 5'd2, 5'd0, 5'd0),
            0, 2'b00, 2'b00);
    drain();

    // Taken branch while decode holds a load-use hazard
    id_valid = 1'b1;
    id_instr = enc_lw(5'd6, 5'd2);
    tick();
    id_instr = enc_r(7'b0, 5'd7, 5'd6, 5'd6);
    br_taken = 1'b1;
    #1 check("br_flush", 32'(flush_if_id), 32'd1);
    check("br_rdy", 32'(id_ready), 32'd0);
    tick();
    check("br_bubble", 32'(bubble), 32'd0);
    check("br_cnt", 32'(stall_cnt), 32'(exp_cnt));
    br_taken = 1'b0;
    #1 check("br_flush_off", 32'(flush_if_id), 32'd0);
    drain();

    // Saturation of the 2-bit counter with more than three stall cycles
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_cnt = 0;
    for (int p = 0; p < SAT_PAIRS; p++)
      run_dep("sat", enc_lw(5'd6, 5'd2), enc_r(7'b0, 5'd7, 5'd6, 5'd6),
              LD_STALLS, LD_FWD, LD_FWD);
    check("sat_w2_cnt", 32'(stall_cnt2), 32'd3);
    check("sat_w16_cnt", 32'(stall_cnt), 32'(exp_cnt));

    // Reset in the middle of a stall
    id_valid = 1'b1;
    id_instr = enc_lw(5'd6, 5'd2);
    tick();
    id_instr = enc_r(7'b0, 5'd7, 5'd6, 5'd6);
    #1 check("mid_rdy_stall", 32'(id_ready), 32'd0);
    rst = 1'b0;
    tick();
    check("mid_rdy",    32'(id_ready),   32'd0);
    check("mid_bubble", 32'(bubble),     32'd0);
    check("mid_fwd_a",  32'(fwd_a_sel),  32'd0);
    check("mid_fwd_b",  32'(fwd_b_sel),  32'd0);
    check("mid_cnt",    32'(stall_cnt),  32'd0);
    check("mid_cnt_w2", 32'(stall_cnt2), 32'd0);
    check("mid_flush",  32'(flush_if_id), 32'd0);
    rst = 1'b1;
    #1 check("post_rst_rdy", 32'(id_ready), 32'd1);
    tick();
    check("post_rst_bubble", 32'(bubble), 32'd0);
    check("post_rst_cnt", 32'(stall_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_hazard_scheduler.md
RISCV_HAZARD_SCHEDULER -- requirements
Module: riscv_hazard_scheduler

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 16, which is the width of the stall-cycle counter.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port id_valid  in  1  the decode stage holds a valid instruction.
REQ-005 SHALL have port id_instr  in  32  the instruction in the decode stage.
REQ-006 SHALL have port br_taken  in  1  the branch/jump in the EX slot resolved taken this cycle.
REQ-007 SHALL have port id_ready  out  1  the decode instruction issues to EX at this edge (combinational).
REQ-008 SHALL have port flush_if_id  out  1  kill the fetch and decode instructions (combinational, equals br_taken).
REQ-009 SHALL have port bubble  out  1  registered; the EX slot holds an inserted bubble this cycle.
REQ-010 SHALL have ports fwd_a_sel / fwd_b_sel  out  2 each  registered rs1/rs2 operand source for the instruction now in EX: 00 = GPR, 01 = MEM-stage result, 10 = WB-stage result.
REQ-011 SHALL have port stall_cnt  out  STALL_CNT_W  count of hazard stall cycles, saturating.

Function
REQ-012 SHALL decode rs1 = id_instr[19:15], rs2 = [24:20], rd = [11:7] and opcode = [6:0].
REQ-013 SHALL treat rs1 as read for R (0110011), I (0010011), S (0100011), B (1100011) and load (0000011) opcodes.
REQ-014 SHALL treat rs2 as read for R, S and B opcodes.
REQ-015 SHALL treat rd as written for R, I, U (0110111), J (1101111) and load opcodes, and only when rd != 0.
REQ-016 SHALL track three in-flight slots, EX, MEM and WB, each holding {valid, writes, rd, is_load}.
REQ-017 SHALL advance the slots every cycle: WB<=MEM, MEM<=EX, EX<=issued decode instruction or an invalid entry.
REQ-018 SHALL treat a source register as hazardous when it is read, is nonzero, and equals the rd of a valid slot with writes=1, subject to REQ-033/REQ-034.
REQ-019 SHALL drive id_ready = ~hazard & ~br_taken, so id_ready is 0 in any cycle where br_taken=1.
REQ-020 SHALL, when id_valid=1 and hazard=1, load an invalid entry into EX, set bubble=1 next cycle and increment stall_cnt.
REQ-021 SHALL saturate stall_cnt at all-ones.
REQ-022 SHALL, when br_taken=1, load an invalid entry into EX; bubble=0, stall_cnt unchanged, and br_taken takes priority over hazard.
REQ-023 SHALL, when id_valid=0, load an invalid entry into EX with bubble=0 and no count.
REQ-024 SHALL, on a hazard, keep the instruction stalled in decode and re-evaluate it every cycle until it issues.
REQ-025 SHALL have issue latency 0 cycles when there is no hazard, and stall length of 1 to 3 cycles per REQ-033/REQ-034.

Reset
REQ-026 SHALL, when rst=0 at a clock edge, clear all slots to invalid.
REQ-027 SHALL, on that same edge, set bubble=0, fwd_a_sel=fwd_b_sel=00 and stall_cnt=0.
REQ-028 SHALL drive id_ready=0 while rst=0.
REQ-029 SHALL, on reset mid-stall, discard the pending hazard; the first cycle after release sees empty slots.

Configuration
REQ-030 SHALL use macro RISCV_HAZARD_FORWARDING_EN to select the hazard and forwarding mode.
REQ-031 SHALL, when the macro is defined, compute fwd_*_sel as below and register it as the instruction issues.
REQ-032 SHALL give forwarding priority to the youngest producer: 01 if the EX slot matches, else 10 if the MEM slot matches.
REQ-033 SHALL, when the macro is defined, raise a hazard only for an EX-slot match with is_load=1 (load-use), giving a 1-cycle stall.
REQ-034 SHALL, when the macro is undefined, raise a hazard on a match in any of the EX, MEM or WB slots (up to 3-cycle stall), and tie fwd_*_sel to 00.

Verification
REQ-035 SHALL verify, without the macro: add x1,x2,x3 then sub x4,x1,x5 -> id_ready low 3 cycles, 3 bubbles, stall_cnt=3, fwd 00.
REQ-036 SHALL verify, with the macro, the same pair -> no stall, stall_cnt=0, fwd_a_sel=01 when sub is in EX, fwd_b_sel=00.
REQ-037 SHALL verify, with the macro: lw x6 then add x7,x6,x6 -> 1 bubble, stall_cnt=1, fwd_a_sel=fwd_b_sel=10 when add is in EX.
REQ-038 SHALL verify: addi x0,x0,5 then add x2,x0,x0 -> no stall in either build.
REQ-039 SHALL verify: br_taken=1 while decode holds a hazard -> flush_if_id=1, id_ready=0, bubble=0, stall_cnt unchanged.
REQ-040 SHALL verify, with STALL_CNT_W=2 and 5 stall cycles, that stall_cnt holds 3; then rst=0 mid-stall -> all outputs 0 next cycle.
